// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS instruction fetch with IF/ID register, SRAM-like req/addr_ok/
//            data_ok port, delay-slot redirects, stall hold buffer and flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(32'hBFC0_0000)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallF,
  input  logic          flushD,
  input  logic          pcsrcD,
  input  logic [AW-1:0] pcbranchD,
  input  logic          jumpD,
  input  logic [AW-1:0] pcjumpD,
  output logic          inst_req,
  output logic [AW-1:0] inst_addr,
  input  logic          inst_addr_ok,
  input  logic          inst_data_ok,
  input  logic [31:0]   inst_rdata,
  output logic [31:0]   instrD,
  output logic [AW-1:0] pcD,
  output logic [AW-1:0] pcplus4D,
  output logic          validD,
  output logic          fetch_busy
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_redir_target;
  logic          r_redir_pending;
  logic [31:0]   r_hold;
  logic [AW-1:0] w_pc_plus4;
  logic [AW-1:0] w_next_pc;
  logic [AW-1:0] w_redir_sel;
  logic [31:0]   w_instr;
  logic          w_deliver;
  logic          w_hold_capture;
  logic          w_redirect;

  always_comb begin
    w_state_nxt    = r_state;
    inst_req       = 1'b0;
    fetch_busy     = 1'b0;
    w_deliver      = 1'b0;
    w_hold_capture = 1'b0;
    w_instr        = inst_rdata;
    case (r_state)
      ST_REQ: begin
        inst_req   = rst;
        fetch_busy = rst;
        if (inst_addr_ok) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        fetch_busy = rst && !inst_data_ok;
        if (inst_data_ok) begin
          if (stallF) begin
            w_hold_capture = 1'b1;
            w_state_nxt    = ST_HOLD;
          end else begin
            w_deliver   = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        w_instr = r_hold;
        if (!stallF) begin
          w_deliver   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  assign inst_addr   = r_pc;
  assign w_pc_plus4  = r_pc + AW'(4);
  // A redirect waiting for the delay slot wins over sequential fetch.
  assign w_next_pc   = r_redir_pending ? r_redir_target : w_pc_plus4;
  assign w_redirect  = !stallF && (jumpD || pcsrcD);
  assign w_redir_sel = jumpD ? pcjumpD : pcbranchD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc            <= RESET_PC;
      r_redir_pending <= 1'b0;
      r_redir_target  <= '0;
    end else begin
      if (w_deliver) begin
        r_pc <= w_next_pc;
      end
      // A fresh redirect outlives a coincident delivery: that one was the delay slot.
      if (w_redirect) begin
        r_redir_pending <= 1'b1;
        r_redir_target  <= w_redir_sel;
      end else if (w_deliver) begin
        r_redir_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (w_hold_capture) begin
      r_hold <= inst_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instrD   <= '0;
      pcD      <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD <= '0;
      validD <= 1'b0;
    end else if (w_deliver) begin
      instrD   <= w_instr;
      pcD      <= r_pc;
      pcplus4D <= w_pc_plus4;
      validD   <= 1'b1;
    end else if (!stallF) begin
      instrD <= '0;
      validD <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed vector table,
//            hand-written corner sequences and a randomized reference-model run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RPC  = 32'hBFC0_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, stallF, flushD, pcsrcD, jumpD, inst_addr_ok, inst_data_ok;
  logic [31:0] pcbranchD, pcjumpD, inst_rdata;
  logic        inst_req, validD, fetch_busy;
  logic [31:0] inst_addr, instrD, pcD, pcplus4D;
  logic        inst_req2, validD2, fetch_busy2;
  logic [31:0] inst_addr2, instrD2, pcD2, pcplus4D2;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallF(stallF), .flushD(flushD), .pcsrcD(pcsrcD),
    .pcbranchD(pcbranchD), .jumpD(jumpD), .pcjumpD(pcjumpD),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .instrD(instrD),
    .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD), .fetch_busy(fetch_busy)
  );

  fetch_stage #(.RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst(rst), .stallF(stallF), .flushD(flushD), .pcsrcD(pcsrcD),
    .pcbranchD(pcbranchD), .jumpD(jumpD), .pcjumpD(pcjumpD),
    .inst_req(inst_req2), .inst_addr(inst_addr2), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .instrD(instrD2),
    .pcD(pcD2), .pcplus4D(pcplus4D2), .validD(validD2), .fetch_busy(fetch_busy2)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // memory: contents are a fixed function of the address
  bit          mem_busy = 0;
  int          mem_age  = 0;
  int          min_lat  = 1;
  bit          force_dok = 0;
  logic [31:0] mem_addr = '0;

  // reference model: fetch pipeline at transaction level
  bit          m_o, m_b, m_pend, m_valid;
  logic [31:0] m_pc, m_tgt, m_instr, m_pcD, m_pcp4;

  // values seen in the last sampled cycle
  logic        s_req, s_valid, s_busy;
  logic [31:0] s_addr, s_addr2, s_instr, s_pcD;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit aok, input bit dok, input bit st,
                            input bit fl, input bit br, input bit jp,
                            input logic [31:0] bt, input logic [31:0] jt, input bit req_e);
    bit          avail, del;
    logic [31:0] npc;
    if (!r) begin
      m_pc = RPC; m_o = 0; m_b = 0; m_pend = 0;
      m_instr = '0; m_pcD = '0; m_pcp4 = '0; m_valid = 0;
    end else begin
      avail = (m_o && dok) || m_b;
      del   = avail && !st;
      npc   = m_pend ? m_tgt : m_pc + 32'd4;
      if (fl) begin
        m_instr = '0; m_valid = 0;
      end else if (del) begin
        m_instr = memf(m_pc); m_pcD = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1;
      end else if (!st) begin
        m_instr = '0; m_valid = 0;
      end
      if (m_o && dok && st) m_b = 1;
      if (m_o && dok) m_o = 0;
      if (del) begin
        m_b = 0; m_pc = npc; m_pend = 0;
      end
      if (!st && (jp || br)) begin
        m_pend = 1; m_tgt = jp ? jt : bt;
      end
      if (req_e && aok) m_o = 1;
    end
  endtask

  // One clock cycle: drive inputs, check against the model, then advance.
  task automatic step(input bit r, input bit ao, input bit dk, input bit st, input bit fl,
                      input bit br, input bit jp, input logic [31:0] bt, input logic [31:0] jt);
    bit          aok, dok, req_e, busy_e;
    logic [31:0] a_addr;
    #1;
    rst = r; stallF = st; flushD = fl; pcsrcD = br; jumpD = jp; pcbranchD = bt; pcjumpD = jt;
    #1;
    aok = ao && inst_req;
    dok = force_dok || (dk && mem_busy && mem_age >= min_lat);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = dok ? memf(mem_addr) : $urandom;
    #1;
    req_e  = r && !m_o && !m_b;
    busy_e = r && (req_e || (m_o && !dok));
    a_addr = inst_addr;
    s_req = inst_req; s_addr = inst_addr; s_addr2 = inst_addr2; s_busy = fetch_busy;
    s_valid = validD; s_instr = instrD; s_pcD = pcD;
    if (chk_en) begin
      chk("inst_req", {31'd0, inst_req}, {31'd0, req_e});
      if (req_e) chk("inst_addr", inst_addr, m_pc);
      chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, busy_e});
      chk("instrD", instrD, m_instr);
      chk("pcD", pcD, m_pcD);
      chk("pcplus4D", pcplus4D, m_pcp4);
      chk("validD", {31'd0, validD}, {31'd0, m_valid});
    end
    @(posedge clk);
    if (!r) begin
      mem_busy = 0;
    end else begin
      if (dok) mem_busy = 0;
      if (aok) begin
        mem_busy = 1; mem_addr = a_addr; mem_age = 0;
      end else begin
        mem_age++;
      end
    end
    model_edge(r, aok, dok, st, fl, br, jp, bt, jt, req_e);
  endtask

  typedef struct {
    bit          r, dk, br, jp;
    logic [31:0] bt, jt;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pcD;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit dk, input bit br, input logic [31:0] bt,
                     input bit jp, input logic [31:0] jt, input bit e_req,
                     input logic [31:0] e_addr, input bit e_valid, input logic [31:0] e_pcD);
    vec_t v;
    v.r = r; v.dk = dk; v.br = br; v.jp = jp; v.bt = bt; v.jt = jt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pcD = e_pcD;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] a0, a1, ii;
    logic        iv;
    rst = 0; stallF = 0; flushD = 0; pcsrcD = 0; jumpD = 0;
    pcbranchD = '0; pcjumpD = '0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;

    // reset, then 3-cycle fetch cadence, branch with delay slot, jump priority
    add(0,0, 0,0, 0,0, 0,0,          0,0);
    add(1,0, 0,0, 0,0, 1,RPC,        0,0);
    add(1,0, 0,0, 0,0, 0,0,          0,0);
    add(1,1, 0,0, 0,0, 0,0,          0,0);
    add(1,0, 0,0, 0,0, 1,RPC+32'h4,  1,RPC);
    add(1,0, 0,0, 0,0, 0,0,          0,RPC);
    add(1,1, 0,0, 0,0, 0,0,          0,RPC);
    add(1,0, 0,0, 0,0, 1,RPC+32'h8,  1,RPC+32'h4);
    add(1,0, 0,0, 0,0, 0,0,          0,RPC+32'h4);
    add(1,1, 0,0, 0,0, 0,0,          0,RPC+32'h4);
    add(1,0, 0,0, 0,0, 1,RPC+32'hC,  1,RPC+32'h8);
    add(1,0, 0,0, 0,0, 0,0,          0,RPC+32'h8);
    add(1,1, 0,0, 0,0, 0,0,          0,RPC+32'h8);
    add(1,0, 0,0, 0,0, 1,RPC+32'h10, 1,RPC+32'hC);
    add(1,0, 0,0, 0,0, 0,0,          0,RPC+32'hC);
    add(1,1, 0,0, 0,0, 0,0,          0,RPC+32'hC);
    add(1,0, 1,RPC+32'h100, 0,0, 1,RPC+32'h14, 1,RPC+32'h10);
    add(1,0, 0,0, 0,0, 0,0,          0,RPC+32'h10);
    add(1,1, 0,0, 0,0, 0,0,          0,RPC+32'h10);
    add(1,0, 0,0, 0,0, 1,RPC+32'h100, 1,RPC+32'h14);
    add(1,0, 0,0, 0,0, 0,0,          0,RPC+32'h14);
    add(1,1, 0,0, 0,0, 0,0,          0,RPC+32'h14);
    add(1,0, 1,RPC+32'h300, 1,RPC+32'h200, 1,RPC+32'h104, 1,RPC+32'h100);
    add(1,0, 0,0, 0,0, 0,0,          0,RPC+32'h100);
    add(1,1, 0,0, 0,0, 0,0,          0,RPC+32'h100);
    add(1,0, 0,0, 0,0, 1,RPC+32'h200, 1,RPC+32'h104);

    step(0,0,0,0,0,0,0,'0,'0);
    step(0,0,0,0,0,0,0,'0,'0);
    chk_en  = 1;
    min_lat = 1;
    foreach (tbl[i]) begin
      step(tbl[i].r, 1'b1, tbl[i].dk, 1'b0, 1'b0, tbl[i].br, tbl[i].jp, tbl[i].bt, tbl[i].jt);
      chk($sformatf("tbl%0d.req", i), {31'd0, s_req}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("tbl%0d.addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d.validD", i), {31'd0, s_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d.pcD", i), s_pcD, tbl[i].e_pcD);
      if (i == 1) chk("wrap.first_addr", s_addr2, RPC2);
      if (i == 4) chk("wrap.second_addr", s_addr2, 32'h0000_0000);
    end

    // stallF held 4 cycles across data_ok: hold buffer then delivery
    min_lat = 0;
    step(0,0,0,0,0,0,0,'0,'0);
    step(1,1,0,0,0,0,0,'0,'0);
    a0 = s_addr;
    step(1,0,1,1,0,0,0,'0,'0);
    iv = s_valid; ii = s_instr;
    for (int k = 0; k < 3; k++) begin
      step(1,0,0,1,0,0,0,'0,'0);
      chk("stall.req", {31'd0, s_req}, 32'd0);
      chk("stall.validD", {31'd0, s_valid}, {31'd0, iv});
      chk("stall.instrD", s_instr, ii);
    end
    step(1,0,0,0,0,0,0,'0,'0);
    step(1,0,0,0,0,0,0,'0,'0);
    chk("stall.release_instr", s_instr, memf(a0));
    chk("stall.release_valid", {31'd0, s_valid}, 32'd1);
    chk("stall.release_pcD", s_pcD, a0);

    // addr_ok withheld 5 cycles
    a1 = s_addr;
    for (int k = 0; k < 5; k++) begin
      step(1,0,0,0,0,0,0,'0,'0);
      chk("wait.req", {31'd0, s_req}, 32'd1);
      chk("wait.addr", s_addr, a1);
      chk("wait.busy", {31'd0, s_busy}, 32'd1);
    end

    // flushD coincident with a delivery
    step(1,1,0,0,0,0,0,'0,'0);
    step(1,0,1,0,1,0,0,'0,'0);
    step(1,0,0,0,0,0,0,'0,'0);
    chk("flush.validD", {31'd0, s_valid}, 32'd0);
    chk("flush.instrD", s_instr, 32'd0);
    chk("flush.next_addr", s_addr, a1 + 32'd4);

    // reset while a response is outstanding; stray data_ok right after release
    step(1,1,0,0,0,0,0,'0,'0);
    step(0,0,1,0,0,0,0,'0,'0);
    force_dok = 1;
    step(1,0,0,0,0,0,0,'0,'0);
    force_dok = 0;
    chk("rstresp.req", {31'd0, s_req}, 32'd1);
    chk("rstresp.addr", s_addr, RPC);
    chk("rstresp.validD", {31'd0, s_valid}, 32'd0);
    chk("rstresp.instrD", s_instr, 32'd0);
    chk("rstresp.pcD", s_pcD, 32'd0);
    step(1,1,0,0,0,0,0,'0,'0);
    chk("rstresp.ignored_dok", {31'd0, s_valid}, 32'd0);
    step(1,0,1,0,0,0,0,'0,'0);
    step(1,0,0,0,0,0,0,'0,'0);
    chk("rstresp.first_pcD", s_pcD, RPC);
    chk("rstresp.first_instr", s_instr, memf(RPC));

    // randomized traffic against the reference model
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(99) != 0, $urandom_range(9) < 7, $urandom_range(9) < 6,
           $urandom_range(3) == 0, $urandom_range(19) == 0,
           $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
